// File: rtl/if_id_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the IF/ID instruction queue.
// master = fetch/decode side, slave = the queue itself.
interface if_id_fetch_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
);
    localparam int OCNT_W = $clog2(DEPTH + 1);

    logic              iValid;
    logic              iReady;
    logic [DATA_W-1:0] iInstruction;
    logic [ADDR_W-1:0] iPC;
    logic [ADDR_W-1:0] iPCPlus4;
    logic              Stall;
    logic              Flush;
    logic              oValid;
    logic [DATA_W-1:0] oInstruction;
    logic [ADDR_W-1:0] oPC;
    logic [ADDR_W-1:0] oPCPlus4;
    logic [OCNT_W-1:0] oCount;
    logic [CNT_W-1:0]  oStallCycles;

    modport master (
        output iValid, iInstruction, iPC, iPCPlus4, Stall, Flush,
        input  iReady, oValid, oInstruction, oPC, oPCPlus4, oCount, oStallCycles
    );

    modport slave (
        input  iValid, iInstruction, iPC, iPCPlus4, Stall, Flush,
        output iReady, oValid, oInstruction, oPC, oPCPlus4, oCount, oStallCycles
    );
endinterface

// File: rtl/if_id_fetch_queue.sv
// In-order DEPTH-entry IF/ID instruction queue with one-cycle flush and stall counter.
// Latency: entry written at edge t is presented to ID in cycle t+1, no bypass.
// Backpressure: iReady depends on registered occupancy only; full queue holds IF off.
module if_id_fetch_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    if_id_fetch_queue_if.slave   q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc_plus4;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic   in_rdy;
    logic   out_vld;
    logic   enq;
    logic   deq;
    entry_t head;

    assign in_rdy  = (count_q < DEPTH_C);
    assign out_vld = (count_q != '0);
    assign enq     = q.iValid && in_rdy && !q.Flush;
    assign deq     = out_vld && !q.Stall && !q.Flush;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        stall_cnt_d = stall_cnt_q;

        if (enq) begin
            mem_d[wr_ptr_q] = '{instr: q.iInstruction, pc: q.iPC, pc_plus4: q.iPCPlus4};
            wr_ptr_d        = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flush discards queue state but keeps the debug stall history.
        if (q.Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end

        if (out_vld && q.Stall && !q.Flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Payload storage needs no reset: it is only observed through out_vld gating.
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    assign q.iReady       = in_rdy;
    assign q.oValid       = out_vld;
    assign q.oInstruction = out_vld ? head.instr    : '0;
    assign q.oPC          = out_vld ? head.pc       : '0;
    assign q.oPCPlus4     = out_vld ? head.pc_plus4 : '0;
    assign q.oCount       = count_q;
    assign q.oStallCycles = stall_cnt_q;
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed self-checking bench for if_id_fetch_queue (DEPTH=4, CNT_W=4).
module tb_if_id_fetch_queue;
    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    if_id_fetch_queue_if #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .CNT_W(4)) bus ();

    if_id_fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .CNT_W(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .q     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.iValid       = v;
        bus.iInstruction = instr;
        bus.iPC          = pc;
        bus.iPCPlus4     = pc + 32'd4;
    endtask

    task automatic check_head(input string tag, input logic [31:0] instr, input logic [31:0] pc);
        check({tag, "_vld"}, 64'(bus.oValid), 64'd1);
        check({tag, "_ins"}, 64'(bus.oInstruction), 64'(instr));
        check({tag, "_pc"},  64'(bus.oPC), 64'(pc));
        check({tag, "_pc4"}, 64'(bus.oPCPlus4), 64'(pc + 32'd4));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b0;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);

        // Reset held for two edges, with an instruction offered to prove it is ignored
        offer(1'b1, 32'h12345678, 32'h80);
        tick();
        tick();
        check("rst_vld", 64'(bus.oValid), 64'd0);
        check("rst_ins", 64'(bus.oInstruction), 64'd0);
        check("rst_pc",  64'(bus.oPC), 64'd0);
        check("rst_pc4", 64'(bus.oPCPlus4), 64'd0);
        check("rst_cnt", 64'(bus.oCount), 64'd0);
        check("rst_stc", 64'(bus.oStallCycles), 64'd0);
        check("rst_rdy", 64'(bus.iReady), 64'd1);

        // Single pass
        Reset = 1'b1;
        offer(1'b1, 32'h2108000A, 32'h40);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check_head("pass", 32'h2108000A, 32'h40);
        check("pass_cnt", 64'(bus.oCount), 64'd1);

        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        check("clr_cnt", 64'(bus.oCount), 64'd0);

        // Fill under stall
        bus.Stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            offer(1'b1, 32'h1000_0000 + 32'(k), 32'(4 * k));
            tick();
        end
        check("fill_cnt", 64'(bus.oCount), 64'd4);
        check("fill_rdy", 64'(bus.iReady), 64'd0);
        check_head("fill_head", 32'h1000_0000, 32'h0);
        offer(1'b1, 32'h1000_0004, 32'h10);
        tick();
        check("full_cnt", 64'(bus.oCount), 64'd4);
        check("full_pc", 64'(bus.oPC), 64'h0);
        check("full_stc", 64'(bus.oStallCycles), 64'd4);

        // Release stall: first edge only drains (full), then entries 4 and 5 enter
        bus.Stall = 1'b0;
        tick();
        check_head("drain1", 32'h1000_0001, 32'h4);
        check("drain1_cnt", 64'(bus.oCount), 64'd3);
        check("drain1_rdy", 64'(bus.iReady), 64'd1);
        tick();
        check_head("drain2", 32'h1000_0002, 32'h8);
        check("drain2_cnt", 64'(bus.oCount), 64'd3);
        offer(1'b1, 32'h1000_0005, 32'h14);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check_head("drain3", 32'h1000_0003, 32'hC);
        check("drain3_cnt", 64'(bus.oCount), 64'd3);
        tick();
        check_head("drain4", 32'h1000_0004, 32'h10);
        tick();
        check_head("drain5", 32'h1000_0005, 32'h14);
        tick();
        check("drain_empty", 64'(bus.oValid), 64'd0);
        check("drain_empty_ins", 64'(bus.oInstruction), 64'd0);

        // Stall on an empty queue leaves the bubble in place and does not count
        bus.Stall = 1'b1;
        tick();
        check("empty_stall_vld", 64'(bus.oValid), 64'd0);
        check("empty_stall_stc", 64'(bus.oStallCycles), 64'd4);

        // Simultaneous enqueue/dequeue at count 2, pointers wrap
        for (int j = 0; j < 2; j++) begin
            offer(1'b1, 32'hA000_0000 | 32'(j), 32'h100 + 32'(4 * j));
            tick();
        end
        check("sim_cnt0", 64'(bus.oCount), 64'd2);
        bus.Stall = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            offer(1'b1, 32'hA000_0000 | 32'(n + 1), 32'h100 + 32'(4 * (n + 1)));
            tick();
            check($sformatf("sim_cnt%0d", n), 64'(bus.oCount), 64'd2);
            check($sformatf("sim_pc%0d", n), 64'(bus.oPC), 64'(32'h100 + 32'(4 * n)));
            check($sformatf("sim_ins%0d", n), 64'(bus.oInstruction), 64'(32'hA000_0000 | 32'(n)));
        end

        // Flush priority at count 3 with iValid and Stall also asserted
        bus.Stall = 1'b1;
        offer(1'b1, 32'hA000_000C, 32'h130);
        tick();
        check("pre_flush_cnt", 64'(bus.oCount), 64'd3);
        check("pre_flush_stc", 64'(bus.oStallCycles), 64'd6);
        bus.Flush = 1'b1;
        offer(1'b1, 32'hDEADBEEF, 32'h200);
        tick();
        bus.Flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check("flush_cnt", 64'(bus.oCount), 64'd0);
        check("flush_vld", 64'(bus.oValid), 64'd0);
        check("flush_ins", 64'(bus.oInstruction), 64'd0);
        check("flush_stc", 64'(bus.oStallCycles), 64'd6);
        tick();
        check("flush_absent", 64'(bus.oCount), 64'd0);

        // Stall counter saturation
        offer(1'b1, 32'hB000_0000, 32'h300);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 8) check("sat_reach", 64'(bus.oStallCycles), 64'd15);
        end
        check("sat_hold", 64'(bus.oStallCycles), 64'd15);
        check("sat_head", 64'(bus.oPC), 64'h300);
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        check("sat_flush", 64'(bus.oStallCycles), 64'd15);

        // Reset mid-operation with count 3 and stall active
        for (int k = 0; k < 3; k++) begin
            offer(1'b1, 32'hC000_0000 | 32'(k), 32'h400 + 32'(4 * k));
            tick();
        end
        check("mid_cnt", 64'(bus.oCount), 64'd3);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        offer(1'b0, 32'h0, 32'h0);
        check("mid_rst_cnt", 64'(bus.oCount), 64'd0);
        check("mid_rst_vld", 64'(bus.oValid), 64'd0);
        check("mid_rst_stc", 64'(bus.oStallCycles), 64'd0);
        check("mid_rst_rdy", 64'(bus.iReady), 64'd1);
        tick();
        check("post_rst_cnt", 64'(bus.oCount), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry in-order instruction queue between the fetch stage and the decode stage.
- Decouples fetch from decode hazards. IF keeps fetching while ID stalls, and a taken branch or jump flushes every queued instruction in one cycle.
- Presents the head instruction, its PC and its PC+4 to ID, with a valid flag and a NOP bubble when the queue is empty.
- Adds occupancy and stall-cycle visibility for debug.

Parameters:
- DATA_W, 32, instruction width.
- ADDR_W, 32, PC width.
- DEPTH, 4, queue entries. Legal range is DEPTH >= 2; any integer is allowed, not only powers of two.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset (0 = reset, sampled on Clk rising edge).
- iValid  in  1  IF presents a fetched instruction this cycle.
- iReady  out  1  queue can accept an instruction this cycle.
- iInstruction  in  DATA_W  fetched instruction word.
- iPC  in  ADDR_W  address of the fetched instruction.
- iPCPlus4  in  ADDR_W  iPC+4 as computed by IF.
- Stall  in  1  ID hazard stall; the head entry must not be consumed this cycle.
- Flush  in  1  taken branch/jump resolved; discard all queued entries.
- oValid  out  1  head entry is valid.
- oInstruction  out  DATA_W  head instruction; 0 (NOP) when oValid=0.
- oPC  out  ADDR_W  head PC; 0 when oValid=0.
- oPCPlus4  out  ADDR_W  head PC+4; 0 when oValid=0.
- oCount  out  clog2(DEPTH+1)  number of valid entries.
- oStallCycles  out  CNT_W  saturating count of cycles where oValid=1 and Stall=1.

Behaviour:
- Reset (Reset=0 at a rising edge):
  - read pointer, write pointer and count go to 0; oValid=0.
  - oInstruction, oPC, oPCPlus4 and oStallCycles go to 0.
  - Storage contents are don't-care.
  - Reset overrides all other inputs, including mid-stall and mid-flush.
- iReady:
  - iReady = (count < DEPTH), decoded from registered count only.
  - No combinational path from Stall, Flush or iValid to iReady.
- Enqueue: iValid && iReady && !Flush. Writes {iInstruction, iPC, iPCPlus4} at the write pointer; write pointer advances.
- Dequeue: oValid && !Stall && !Flush. Read pointer advances.
- Pointers wrap from DEPTH-1 to 0 by explicit compare, not by truncation.
- Count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - unchanged on simultaneous enqueue and dequeue.
  - A simultaneous enqueue and dequeue is legal while count=DEPTH? No: iReady=0 when full, so no enqueue is accepted that cycle. The dequeue still occurs.
- Outputs:
  - oValid = (count != 0).
  - oInstruction, oPC and oPCPlus4 are driven from the head storage entry gated by oValid, from registers only.
- Latency:
  - An instruction enqueued at edge t into an empty queue is visible on the outputs (oValid=1) during cycle t+1, which matches single-register IF/ID timing.
  - No same-cycle bypass.
- Flush:
  - Highest priority after Reset.
  - At the edge both pointers and the count go to 0, and oValid=0 in the next cycle.
  - The instruction offered on iInstruction in the flush cycle is discarded.
  - Stall is ignored during Flush.
  - oStallCycles is not cleared by Flush.
- Stall with empty queue: no effect; the output stays the NOP bubble.
- Stall with full queue: iReady=0. IF must hold its instruction; the queue does not drop or overwrite it.
- oStallCycles:
  - +1 each edge where oValid && Stall && !Flush.
  - Saturates at 2^CNT_W-1; never wraps.
  - Cleared only by Reset.
- Ordering: strictly FIFO. The {instruction, PC, PC+4} triple of an entry always stays together.

Test Plan:
- Reset then single pass: assert Reset=0 for 2 cycles, release, enqueue 0x2108000A / PC 0x00000040. Required: oValid=0 and all outputs 0 during reset; next cycle oValid=1, oInstruction=0x2108000A, oPC=0x40, oPCPlus4=0x44, oCount=1.
- Fill under stall (DEPTH=4): hold Stall=1, offer 6 consecutive instructions PC 0x0..0x14. Required: iReady drops after the 4th accept, oCount=4, head stays PC 0x0. Release Stall: outputs PC 0x0, 0x4, 0x8, 0xC in order with no loss, and the last two accept after space frees.
- Simultaneous enqueue/dequeue: count=2, iValid=1, Stall=0 for 10 cycles. Required: oCount stays 2, pointers wrap past 3 to 0, and output order matches input order.
- Flush priority: count=3, assert Flush with iValid=1 and Stall=1 in the same cycle. Required: next cycle oCount=0, oValid=0, oInstruction=0; the offered instruction is absent; oStallCycles unchanged by the flush.
- Stall counter saturation (CNT_W=4): oValid=1, Stall=1 for 20 cycles. Required: oStallCycles reaches 15 and holds; it is not reset by a subsequent Flush and returns to 0 on Reset=0.
- Reset mid-operation: count=3 and Stall=1, pulse Reset=0 for one edge. Required: oCount=0, oValid=0, oStallCycles=0, and iReady=1 the following cycle.
